prog_clock_divider: RTL and testbench

Runtime-programmable clock-enable/clock divider for the synthesizer's timing chain (note-rate, sample-rate and envelope ticks). It generalises the fixed divide-by-2n divider with several additions:
- parametrised counter width;
- divisor and output mode loadable at run time;
- divisor and mode changes take effect only at a period boundary, so no runt pulses;
- enable and phase-sync controls;
- a one-cycle tick output for downstream enables.

---
 rtl/prog_clock_divider_pkg.sv | 11 +
 rtl/prog_clock_divider.sv | 96 +++++++++
 tb/tb_prog_clock_divider.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/prog_clock_divider_pkg.sv
// Shared definitions for the timing-chain dividers (clock divider, note-rate generator).
package prog_clock_divider_pkg;

  localparam int CNT_W_DEF = 16;

  typedef enum logic {
    MODE_SQUARE = 1'b0,
    MODE_PULSE  = 1'b1
  } mode_t;

endpackage

// File: rtl/prog_clock_divider.sv
// Runtime-programmable clock divider with tick output; new settings take effect only at
// a period boundary (terminal count) or on a phase-sync strobe.
module prog_clock_divider
  import prog_clock_divider_pkg::*;
#(
  parameter int   CNT_W        = CNT_W_DEF,
  parameter int   DEFAULT_DIV  = 5,
  parameter logic DEFAULT_MODE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [CNT_W-1:0] div_in,
  input  logic             mode_in,
  input  logic             sync,
  output logic             oclk,
  output logic             tick,
  output logic             pend
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] div_act;
  logic [CNT_W-1:0] div_pend;
  mode_t            mode_act;
  mode_t            mode_pend;

  logic [CNT_W-1:0] div_req;
  mode_t            mode_req;
  mode_t            mode_next;
  logic             terminal;

  // A zero divisor request is promoted to 1 so the counter compare never underflows.
  always_comb begin
    div_req   = (div_in == '0) ? CNT_W'(1) : div_in;
    mode_req  = mode_t'(mode_in);
    terminal  = en && (cnt == div_act - CNT_W'(1));
    mode_next = pend ? mode_pend : mode_act;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      oclk      <= 1'b0;
      tick      <= 1'b0;
      pend      <= 1'b0;
      div_act   <= CNT_W'(DEFAULT_DIV);
      mode_act  <= mode_t'(DEFAULT_MODE);
      div_pend  <= CNT_W'(DEFAULT_DIV);
      mode_pend <= mode_t'(DEFAULT_MODE);
    end else if (sync) begin
      cnt  <= '0;
      oclk <= 1'b0;
      tick <= 1'b0;
      pend <= 1'b0;
      // A simultaneous load bypasses the pending slot and applies straight away.
      if (load) begin
        div_act   <= div_req;
        mode_act  <= mode_req;
        div_pend  <= div_req;
        mode_pend <= mode_req;
      end else if (pend) begin
        div_act  <= div_pend;
        mode_act <= mode_pend;
      end
    end else begin
      if (en) begin
        if (terminal) begin
          cnt  <= '0;
          tick <= 1'b1;
          if (pend) begin
            div_act  <= div_pend;
            mode_act <= mode_pend;
            pend     <= 1'b0;
          end
          // The mode taking effect at this boundary decides the output edge.
          if (mode_next == MODE_SQUARE) oclk <= ~oclk;
          else                          oclk <= 1'b1;
        end else begin
          cnt  <= cnt + CNT_W'(1);
          tick <= 1'b0;
          if (mode_act == MODE_PULSE) oclk <= 1'b0;
        end
      end else begin
        tick <= 1'b0;
      end
      // Placed last so a load coinciding with a terminal count stays pending.
      if (load) begin
        div_pend  <= div_req;
        mode_pend <= mode_req;
        pend      <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_prog_clock_divider.sv
// Scoreboard bench for prog_clock_divider: directed vectors push hand-computed outputs,
// a monitor pops one expectation after every clock edge and compares.
module tb_prog_clock_divider;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b1;
  logic        load = 1'b0;
  logic [15:0] div_in = '0;
  logic        mode_in = 1'b0;
  logic        sync = 1'b0;
  logic        oclk;
  logic        tick;
  logic        pend;

  typedef struct {
    int   idx;
    logic oclk;
    logic tick;
    logic pend;
  } exp_t;

  exp_t expq[$];
  int   testsRun = 0;
  int   testsFailed = 0;
  int   vecIdx = 0;
  bit   stimDone = 1'b0;

  prog_clock_divider #(.CNT_W(16), .DEFAULT_DIV(5), .DEFAULT_MODE(1'b0)) dut (
    .clk(clk), .rst(rst), .en(en), .load(load), .div_in(div_in),
    .mode_in(mode_in), .sync(sync), .oclk(oclk), .tick(tick), .pend(pend)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs at the falling edge and record what must follow the next rising edge.
  task automatic applyStimulus(input logic r, input logic e, input logic l, input logic [15:0] d,
                               input logic m, input logic s,
                               input logic eo, input logic et, input logic ep);
    exp_t x;
    @(negedge clk);
    rst = r; en = e; load = l; div_in = d; mode_in = m; sync = s;
    vecIdx++;
    x.idx = vecIdx; x.oclk = eo; x.tick = et; x.pend = ep;
    expq.push_back(x);
  endtask

  task automatic step(input logic eo, input logic et, input logic ep);
    applyStimulus(1'b0, 1'b1, 1'b0, 16'd0, 1'b0, 1'b0, eo, et, ep);
  endtask

  task automatic run(input int n, input logic eo, input logic ep);
    for (int i = 0; i < n; i++) step(eo, 1'b0, ep);
  endtask

  task automatic checkOutput(input exp_t x);
    testsRun++;
    if (oclk !== x.oclk) begin
      testsFailed++;
      $display("[TB] FAIL oclk vec %0d: got %b expected %b", x.idx, oclk, x.oclk);
    end
    testsRun++;
    if (tick !== x.tick) begin
      testsFailed++;
      $display("[TB] FAIL tick vec %0d: got %b expected %b", x.idx, tick, x.tick);
    end
    testsRun++;
    if (pend !== x.pend) begin
      testsFailed++;
      $display("[TB] FAIL pend vec %0d: got %b expected %b", x.idx, pend, x.pend);
    end
  endtask

  // Monitor: outputs are registered, so every rising edge presents a new result.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (expq.size() > 0) checkOutput(expq.pop_front());
    end
  end

  initial begin
    // Reset held three cycles, then default N=5 square
    repeat (3) applyStimulus(1'b1, 1'b1, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    run(4, 1'b0, 1'b0); step(1'b1, 1'b1, 1'b0);
    run(4, 1'b1, 1'b0); step(1'b0, 1'b1, 1'b0);
    run(4, 1'b0, 1'b0); step(1'b1, 1'b1, 1'b0);

    // Mid-period reload to N=3 while cnt=2
    run(2, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 16'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    run(2, 1'b0, 1'b0); step(1'b1, 1'b1, 1'b0);
    run(2, 1'b1, 1'b0); step(1'b0, 1'b1, 1'b0);

    // Pulse mode N=4, then div_in=0 acting as N=1
    applyStimulus(1'b0, 1'b1, 1'b1, 16'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0);
    run(3, 1'b0, 1'b0); step(1'b1, 1'b1, 1'b0);
    run(3, 1'b0, 1'b0); step(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    run(2, 1'b0, 1'b1);
    repeat (5) step(1'b1, 1'b1, 1'b0);

    // Load at a terminal count stays pending; pulse->square toggles from oclk=1
    applyStimulus(1'b0, 1'b1, 1'b1, 16'd5, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b0);

    // Enable gating for 7 cycles at cnt=2, with a load accepted while frozen
    run(4, 1'b0, 1'b0); step(1'b1, 1'b1, 1'b0);
    run(2, 1'b1, 1'b0);
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 16'd5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    run(2, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b0);

    // Sync together with load of 6, then sync applying a pending N=2 while oclk=1
    applyStimulus(1'b0, 1'b1, 1'b1, 16'd6, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    run(5, 1'b0, 1'b0); step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 16'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0, 16'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0); step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0); step(1'b0, 1'b1, 1'b0);

    // Back-to-back loads: 7 applies at the collision edge, then 3 is overwritten by 4
    applyStimulus(1'b0, 1'b1, 1'b1, 16'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b1, 16'd3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b1, 16'd4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    run(5, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    run(3, 1'b0, 1'b0); step(1'b1, 1'b1, 1'b0);

    // Reset while a setting is pending restores N=5 and clears pend
    applyStimulus(1'b0, 1'b1, 1'b1, 16'd7, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    run(4, 1'b0, 1'b0); step(1'b1, 1'b1, 1'b0);

    @(negedge clk);
    load = 1'b0; sync = 1'b0;
    stimDone = 1'b1;
  end

  // Drain the scoreboard with a bounded wait, then report.
  initial begin
    int budget;
    budget = 0;
    while (!stimDone && budget < 5000) begin
      @(posedge clk);
      budget++;
    end
    repeat (3) @(posedge clk);
    testsRun++;
    if (!stimDone || expq.size() != 0) begin
      testsFailed++;
      $display("[TB] FAIL drain: done=%0b leftover=%0d expected done=1 leftover=0", stimDone, expq.size());
    end
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
